// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the FSM state encoding, the bubble instruction word and the default counter width.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          DEF_CNT_W = 16;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on inc, holds at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store per instruction, stalls upstream on a miss,
// injects bubbles into MEM/WB while stalled, and keeps access/miss counters and a sticky error.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      instr_in,
    input  logic             regwrite_in,
    input  logic             halt_in,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_done,
    input  logic             mem_busy,
    input  logic             mem_err,
    output logic [15:0]      mem_out,
    output logic [15:0]      instr_out,
    output logic             regwrite_out,
    output logic             halt_out,
    output logic             stall,
    output logic             err,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    state_t state, nextState;
    logic   memOp, isLoad;
    logic   bubble, incAccess, incMiss, errSet;

    assign memOp     = mem_read | mem_write;
    assign isLoad    = mem_read;  // a conflicting read+write is serviced as a load
    assign mem_addr  = addr;
    assign mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        nextState = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        stall     = 1'b0;
        bubble    = 1'b1;
        mem_out   = 16'h0000;
        incAccess = 1'b0;
        incMiss   = 1'b0;
        errSet    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!memOp) begin
                    bubble = 1'b0;
                end else if (mem_busy) begin
                    stall = 1'b1;
                end else begin
                    mem_rd = isLoad;
                    mem_wr = !isLoad;
                    errSet = mem_read & mem_write;
                    if (mem_done) begin
                        bubble    = 1'b0;
                        mem_out   = isLoad ? mem_rdata : 16'h0000;
                        incAccess = 1'b1;
                        errSet    = errSet | mem_err;
                    end else begin
                        stall     = 1'b1;
                        incMiss   = 1'b1;
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_done) begin
                    bubble    = 1'b0;
                    mem_out   = isLoad ? mem_rdata : 16'h0000;
                    incAccess = 1'b1;
                    errSet    = mem_err;
                    nextState = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase

        // Reset holds the stage quiet even if EX/MEM presents a memory op.
        if (!rst) begin
            nextState = IDLE;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            stall     = 1'b0;
            bubble    = 1'b1;
            mem_out   = 16'h0000;
            incAccess = 1'b0;
            incMiss   = 1'b0;
            errSet    = 1'b0;
        end
    end

    assign instr_out    = bubble ? NOP_INSTR : instr_in;
    assign regwrite_out = bubble ? 1'b0 : regwrite_in;
    assign halt_out     = bubble ? 1'b0 : halt_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (errSet)
            err <= 1'b1;
    end

    sat_cnt #(.W(CNT_W)) u_access_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (incAccess),
        .count(access_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (incMiss),
        .count(miss_cnt)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes one expected record per cycle,
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_mem_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      addr = '0, wdata = '0, instr_in = 16'h0800;
    logic             mem_read = 1'b0, mem_write = 1'b0;
    logic             regwrite_in = 1'b0, halt_in = 1'b0;
    logic [15:0]      mem_rdata = '0;
    logic             mem_done = 1'b0, mem_busy = 1'b0, mem_err = 1'b0;
    logic [15:0]      mem_addr, mem_wdata, mem_out, instr_out;
    logic             mem_rd, mem_wr, regwrite_out, halt_out, stall, err;
    logic [CNT_W-1:0] access_cnt, miss_cnt;

    mem_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .instr_in(instr_in),
        .regwrite_in(regwrite_in), .halt_in(halt_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_busy(mem_busy), .mem_err(mem_err),
        .mem_out(mem_out), .instr_out(instr_out), .regwrite_out(regwrite_out),
        .halt_out(halt_out), .stall(stall), .err(err),
        .access_cnt(access_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             stall, rd, wr, rw, halt, err;
        logic [15:0]      instr, out, addr, wdata;
        logic [CNT_W-1:0] acc, miss;
    } exp_t;

    exp_t             sb[$];
    int               nVec = 0;
    int               nMis = 0;
    logic [CNT_W-1:0] expAcc = '0, expMiss = '0;
    logic             expErr = 1'b0;

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                nVec++;
                if (stall !== e.stall || mem_rd !== e.rd || mem_wr !== e.wr ||
                    instr_out !== e.instr || regwrite_out !== e.rw || halt_out !== e.halt ||
                    mem_out !== e.out || err !== e.err || access_cnt !== e.acc ||
                    miss_cnt !== e.miss || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                    nMis++;
                    $display("FAIL %s: got stall=%b rd=%b wr=%b instr=%h rw=%b halt=%b out=%h err=%b acc=%0d miss=%0d addr=%h wd=%h | want stall=%b rd=%b wr=%b instr=%h rw=%b halt=%b out=%h err=%b acc=%0d miss=%0d addr=%h wd=%h",
                             e.name, stall, mem_rd, mem_wr, instr_out, regwrite_out, halt_out,
                             mem_out, err, access_cnt, miss_cnt, mem_addr, mem_wdata,
                             e.stall, e.rd, e.wr, e.instr, e.rw, e.halt, e.out, e.err,
                             e.acc, e.miss, e.addr, e.wdata);
                end
            end
        end
    end

    // Push this cycle's expectation, advance one clock, then update the counter/err model.
    task automatic tick(input string name, input bit eStall, input bit eRd, input bit eWr,
                        input bit bub, input logic [15:0] eOut,
                        input bit accInc, input bit missInc, input bit errSet);
        exp_t e;
        e.name  = name;
        e.stall = eStall;
        e.rd    = eRd;
        e.wr    = eWr;
        e.instr = bub ? 16'h0800 : instr_in;
        e.rw    = bub ? 1'b0 : regwrite_in;
        e.halt  = bub ? 1'b0 : halt_in;
        e.out   = eOut;
        e.err   = expErr;
        e.acc   = expAcc;
        e.miss  = expMiss;
        e.addr  = addr;
        e.wdata = wdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (accInc && expAcc != '1) expAcc = expAcc + 1'b1;
        if (missInc && expMiss != '1) expMiss = expMiss + 1'b1;
        if (errSet) expErr = 1'b1;
    endtask

    task automatic setOp(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] ins, input logic rw,
                         input logic hl);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        instr_in = ins; regwrite_in = rw; halt_in = hl;
    endtask

    task automatic doReset();
        rst = 1'b0;
        expAcc = '0; expMiss = '0; expErr = 1'b0;
        tick("reset", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        // Reset holds quiet even with a load presented
        setOp(1, 0, 16'h0040, 16'h0000, 16'h4123, 1, 0);
        doReset();

        // Non-memory pass-through, stray mem_done ignored
        setOp(0, 0, 16'h0000, 16'h0000, 16'h1A2B, 1, 1);
        mem_done = 1; mem_rdata = 16'hDEAD;
        tick("nop_passthru", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        mem_done = 0;

        // Load hit
        setOp(1, 0, 16'h0040, 16'h0000, 16'h4201, 1, 0);
        mem_done = 1; mem_rdata = 16'hBEEF;
        tick("load_hit", 0, 1, 0, 0, 16'hBEEF, 1, 0, 0);
        mem_done = 0;

        // Load miss, done 3 cycles after request
        setOp(1, 0, 16'h0080, 16'h0000, 16'h4302, 1, 0);
        mem_rdata = 16'h1234;
        tick("miss_req", 1, 1, 0, 1, 16'h0000, 0, 1, 0);
        tick("miss_wait1", 1, 0, 0, 1, 16'h0000, 0, 0, 0);
        tick("miss_wait2", 1, 0, 0, 1, 16'h0000, 0, 0, 0);
        mem_done = 1;
        tick("miss_done", 0, 0, 0, 0, 16'h1234, 1, 0, 0);
        mem_done = 0;

        // Store blocked by busy for 2 cycles, then a hit
        setOp(0, 1, 16'h00C0, 16'h5A5A, 16'h5403, 0, 0);
        mem_busy = 1; mem_rdata = 16'hFFFF;
        tick("st_busy1", 1, 0, 0, 1, 16'h0000, 0, 0, 0);
        tick("st_busy2", 1, 0, 0, 1, 16'h0000, 0, 0, 0);
        mem_busy = 0; mem_done = 1;
        tick("st_hit", 0, 0, 1, 0, 16'h0000, 1, 0, 0);
        mem_done = 0;

        // Reset during WAIT abandons the access; later done is ignored
        setOp(1, 0, 16'h0100, 16'h0000, 16'h4504, 1, 0);
        tick("rw_req", 1, 1, 0, 1, 16'h0000, 0, 1, 0);
        doReset();
        setOp(0, 0, 16'h0000, 16'h0000, 16'h0605, 0, 0);
        mem_done = 1; mem_rdata = 16'h7777;
        tick("rw_done_ignored", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        mem_done = 0;
        tick("rw_idle", 0, 0, 0, 0, 16'h0000, 0, 0, 0);

        // mem_err on a load hit sets the sticky flag
        setOp(1, 0, 16'h0200, 16'h0000, 16'h4706, 1, 0);
        mem_done = 1; mem_err = 1; mem_rdata = 16'hC0DE;
        tick("err_load", 0, 1, 0, 0, 16'hC0DE, 1, 0, 1);
        mem_done = 0; mem_err = 0;
        for (int i = 0; i < 5; i++) begin
            setOp(0, 0, 16'h0000, 16'h0000, 16'h0100 + 16'(i), 1, 0);
            tick("err_sticky", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        end

        // Conflicting read+write: serviced as a load, flags err
        doReset();
        setOp(1, 1, 16'h0300, 16'h9999, 16'h4807, 1, 0);
        mem_done = 1; mem_rdata = 16'hABCD;
        tick("rdwr_conflict", 0, 1, 0, 0, 16'hABCD, 1, 0, 1);
        mem_done = 0;
        setOp(0, 0, 16'h0000, 16'h0000, 16'h0908, 1, 0);
        tick("rdwr_err_held", 0, 0, 0, 0, 16'h0000, 0, 0, 0);

        // Access counter saturation: 16 load hits with a 4-bit counter
        doReset();
        mem_done = 1;
        for (int i = 0; i < 16; i++) begin
            setOp(1, 0, 16'h0400 + 16'(i), 16'h0000, 16'h4A00 + 16'(i), 1, 0);
            mem_rdata = 16'h1000 + 16'(i);
            tick("sat_hit", 0, 1, 0, 0, 16'h1000 + 16'(i), 1, 0, 0);
        end
        mem_done = 0;
        setOp(0, 0, 16'h0000, 16'h0000, 16'h0B00, 0, 0);
        tick("sat_hold", 0, 0, 0, 0, 16'h0000, 0, 0, 0);

        @(negedge clk);
        if (sb.size() != 0) begin
            nMis++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline, between the EX/MEM register and the MEM/WB register in the direct-mapped-cache build.
- Issues at most one load/store request per instruction to the cache/memory system.
- Freezes the upstream pipeline while a miss is outstanding.
- Presents a bubble (NOP, RegWrite=0, Halt=0) to MEM/WB during stall cycles.
- Keeps saturating access/miss performance counters and a sticky error flag.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- addr  in  16  effective address (ALU result from EX/MEM)
- wdata  in  16  store data
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- instr_in  in  16  instruction word from EX/MEM
- regwrite_in  in  1  RegWrite control from EX/MEM
- halt_in  in  1  Halt from EX/MEM
- mem_addr  out  16  request address (= addr)
- mem_wdata  out  16  request write data (= wdata)
- mem_rd  out  1  load request strobe
- mem_wr  out  1  store request strobe
- mem_rdata  in  16  returned load data, valid with mem_done
- mem_done  in  1  access complete; may rise in the request cycle (hit)
- mem_busy  in  1  memory cannot accept a request this cycle
- mem_err  in  1  access error, sampled with mem_done
- mem_out  out  16  load data to MEM/WB
- instr_out  out  16  instruction to MEM/WB; 16'h0800 during bubbles
- regwrite_out  out  1  RegWrite to MEM/WB; 0 during bubbles
- halt_out  out  1  Halt to MEM/WB; 0 during bubbles
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- err  out  1  sticky access error
- access_cnt  out  CNT_W  completed memory accesses, saturating
- miss_cnt  out  CNT_W  accesses not done in their request cycle, saturating

## Operation
- States: IDLE, WAIT.
- IDLE, no memory op (mem_read=mem_write=0):
  - pass-through: instr_out=instr_in, regwrite_out=regwrite_in, halt_out=halt_in.
  - stall=0, mem_out=0.
- IDLE, memory op, mem_busy=1:
  - no strobe; stall=1; bubble outputs; stay IDLE (retry next cycle).
- IDLE, memory op, mem_busy=0:
  - drive mem_rd or mem_wr for exactly this cycle.
  - If mem_done=1 the same cycle (hit): stall=0, pass-through, mem_out=mem_rdata for loads and 0 for stores; access_cnt+1.
  - Otherwise: stall=1, bubble outputs, go to WAIT; miss_cnt+1.
- WAIT:
  - strobes held 0.
  - mem_done=0: stall=1, bubble outputs.
  - mem_done=1: stall=0, pass-through, mem_out=mem_rdata (load) or 0 (store); access_cnt+1; go to IDLE.
- mem_read and mem_write both 1: treated as a load; err set.
- mem_err sampled only when mem_done=1; sets err, which clears only on reset.
- Counters saturate at all-ones, with no wrap. Both counters increment on the same edge when their conditions coincide.
- Bubble: instr_out=16'h0800, regwrite_out=0, halt_out=0, mem_out=0.

## Timing
- Hit: zero added latency; data reaches MEM/WB on the next edge.
- Miss with done N cycles after the request: stall is high for N cycles. stall drops combinationally in the cycle mem_done rises.
- Exactly one strobe per instruction. Upstream registers are frozen by stall, so inputs are stable through WAIT.
- Reset (rst=0, asynchronous): state=IDLE, err=0, counters=0.
  - While rst=0: stall=0, mem_rd=mem_wr=0, bubble outputs.
  - Reset during WAIT abandons the access. Any later mem_done is ignored until a new request is issued.
- mem_done in IDLE with no strobe issued: ignored.

## Structure
- Package mem_stage_pkg:
  - state enum {IDLE, WAIT}
  - NOP_INSTR = 16'h0800
  - CNT_W default
- One sub-module, sat_cnt: CNT_W-bit saturating incrementer with async active-low reset, instantiated twice.
- FSM, output mux and err flag live in mem_stage.

## Test plan
- Load hit: addr=16'h0040, mem_done in the request cycle with rdata=16'hBEEF -> stall never high, one mem_rd pulse, mem_out=16'hBEEF, access_cnt=1, miss_cnt=0.
- Load miss: mem_done 3 cycles after the request with rdata=16'h1234 -> stall high exactly 3 cycles, instr_out=16'h0800 and regwrite_out=0 during those cycles, single mem_rd, mem_out=16'h1234 on the done cycle, miss_cnt=1.
- Store with mem_busy high for 2 cycles then a hit -> no strobe while busy, stall high 2 cycles, one mem_wr with mem_wdata=wdata, mem_out=0.
- Reset asserted during WAIT, then mem_done pulses -> outputs return to reset values immediately, done ignored, counters 0, no stall.
- mem_err with mem_done on a load -> err=1 and stays 1 across 5 further non-memory instructions until reset.
- Force access_cnt to all-ones (CNT_W=4, 16 hits) -> access_cnt stays 4'hF after the 15th access.
